// File: rtl/dtm_dbus_async_bridge.sv
// Carries one debug-bus request TCK -> core_clk and its response back using toggle handshakes.
// Latency SYNC_STAGES+1 edges per crossing; tck_req_ready stays low until the response is consumed.
`timescale 1ns/1ps
module dtm_dbus_async_bridge #(
  parameter int DEBUG_DATA_BITS = 34,
  parameter int DEBUG_ADDR_BITS = 5,
  parameter int DEBUG_OP_BITS   = 2,
  parameter int SYNC_STAGES     = 2,
  localparam int REQ_BITS  = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
  localparam int RESP_BITS = DEBUG_OP_BITS + DEBUG_DATA_BITS
) (
  input  logic                 jtag_TCK,
  input  logic                 jtag_TRST,
  input  logic                 core_clk,
  input  logic                 tck_req_valid,
  output logic                 tck_req_ready,
  input  logic [REQ_BITS-1:0]  tck_req_bits,
  output logic                 tck_resp_valid,
  input  logic                 tck_resp_ready,
  output logic [RESP_BITS-1:0] tck_resp_bits,
  output logic                 core_req_valid,
  input  logic                 core_req_ready,
  output logic [REQ_BITS-1:0]  core_req_bits,
  input  logic                 core_resp_valid,
  output logic                 core_resp_ready,
  input  logic [RESP_BITS-1:0] core_resp_bits
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  // TCK domain
  logic [REQ_BITS-1:0]    req_data_q, req_data_d;
  logic                   req_tgl_q, req_tgl_d;
  logic                   outstanding_q, outstanding_d;
  logic [RESP_BITS-1:0]   resp_data_q, resp_data_d;
  logic                   resp_seen_q, resp_seen_d;
  logic                   resp_vld_q, resp_vld_d;
  logic [SYNC_STAGES-1:0] resp_tgl_sync_q, resp_tgl_sync_d;
  logic                   resp_tgl_s;

  // core domain
  logic [SYNC_STAGES-1:0] core_rst_sync_q, core_rst_sync_d;
  logic                   core_rst;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] req_tgl_sync_q, req_tgl_sync_d;
  logic                   req_tgl_s;
  logic                   req_seen_q, req_seen_d;
  logic [REQ_BITS-1:0]    core_req_bits_q, core_req_bits_d;
  logic [RESP_BITS-1:0]   resp_reg_q, resp_reg_d;
  logic                   resp_tgl_q, resp_tgl_d;

  assign tck_req_ready  = ~outstanding_q;
  assign tck_resp_valid = resp_vld_q;
  assign tck_resp_bits  = resp_data_q;
  assign resp_tgl_s     = resp_tgl_sync_q[SYNC_STAGES-1];

  always_comb begin
    req_data_d      = req_data_q;
    req_tgl_d       = req_tgl_q;
    outstanding_d   = outstanding_q;
    resp_data_d     = resp_data_q;
    resp_seen_d     = resp_seen_q;
    resp_vld_d      = resp_vld_q;
    resp_tgl_sync_d = {resp_tgl_sync_q[SYNC_STAGES-2:0], resp_tgl_q};

    if (tck_req_valid && !outstanding_q) begin
      req_data_d    = tck_req_bits;
      req_tgl_d     = ~req_tgl_q;
      outstanding_d = 1'b1;
    end

    // resp_reg_q is held by the core side until the next request, so sampling it here is safe
    if (resp_vld_q) begin
      if (tck_resp_ready) begin
        resp_vld_d    = 1'b0;
        resp_seen_d   = resp_tgl_s;
        outstanding_d = 1'b0;
      end
    end else if (resp_tgl_s != resp_seen_q) begin
      resp_vld_d  = 1'b1;
      resp_data_d = resp_reg_q;
    end
  end

  always_ff @(posedge jtag_TCK or posedge jtag_TRST) begin
    if (jtag_TRST) begin
      req_data_q      <= '0;
      req_tgl_q       <= 1'b0;
      outstanding_q   <= 1'b0;
      resp_data_q     <= '0;
      resp_seen_q     <= 1'b0;
      resp_vld_q      <= 1'b0;
      resp_tgl_sync_q <= '0;
    end else begin
      req_data_q      <= req_data_d;
      req_tgl_q       <= req_tgl_d;
      outstanding_q   <= outstanding_d;
      resp_data_q     <= resp_data_d;
      resp_seen_q     <= resp_seen_d;
      resp_vld_q      <= resp_vld_d;
      resp_tgl_sync_q <= resp_tgl_sync_d;
    end
  end

  // Core reset asserts with jtag_TRST, releases after SYNC_STAGES core_clk edges
  assign core_rst_sync_d = {core_rst_sync_q[SYNC_STAGES-2:0], 1'b0};
  assign core_rst        = core_rst_sync_q[SYNC_STAGES-1];

  always_ff @(posedge core_clk or posedge jtag_TRST) begin
    if (jtag_TRST) core_rst_sync_q <= '1;
    else           core_rst_sync_q <= core_rst_sync_d;
  end

  assign req_tgl_s     = req_tgl_sync_q[SYNC_STAGES-1];
  assign core_req_bits = core_req_bits_q;

  always_comb begin
    state_d         = state_q;
    req_tgl_sync_d  = {req_tgl_sync_q[SYNC_STAGES-2:0], req_tgl_q};
    req_seen_d      = req_seen_q;
    core_req_bits_d = core_req_bits_q;
    resp_reg_d      = resp_reg_q;
    resp_tgl_d      = resp_tgl_q;
    core_req_valid  = 1'b0;
    core_resp_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_tgl_s != req_seen_q) begin
          core_req_bits_d = req_data_q;
          req_seen_d      = req_tgl_s;
          state_d         = S_REQ;
        end
      end
      S_REQ: begin
        // a response seen together with the request handshake is left for WAIT
        core_req_valid = 1'b1;
        if (core_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        core_resp_ready = 1'b1;
        if (core_resp_valid) begin
          resp_reg_d = core_resp_bits;
          resp_tgl_d = ~resp_tgl_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q         <= S_IDLE;
      req_tgl_sync_q  <= '0;
      req_seen_q      <= 1'b0;
      core_req_bits_q <= '0;
      resp_reg_q      <= '0;
      resp_tgl_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_tgl_sync_q  <= req_tgl_sync_d;
      req_seen_q      <= req_seen_d;
      core_req_bits_q <= core_req_bits_d;
      resp_reg_q      <= resp_reg_d;
      resp_tgl_q      <= resp_tgl_d;
    end
  end

endmodule

// File: tb/tb_dtm_dbus_async_bridge.sv
// Randomized bench for dtm_dbus_async_bridge: DTM driver, DM responder and queue scoreboard.
`timescale 1ns/1ps
module tb_dtm_dbus_async_bridge;
  localparam int SYNC = 2;
  localparam int RQW  = 41;
  localparam int RSW  = 36;

  logic jtag_TCK  = 1'b0;
  logic core_clk  = 1'b0;
  logic jtag_TRST = 1'b0;
  logic           tck_req_valid, tck_req_ready, tck_resp_valid, tck_resp_ready;
  logic [RQW-1:0] tck_req_bits, core_req_bits;
  logic [RSW-1:0] tck_resp_bits, core_resp_bits;
  logic           core_req_valid, core_req_ready, core_resp_valid, core_resp_ready;

  dtm_dbus_async_bridge #(.SYNC_STAGES(SYNC)) dut (
    .jtag_TCK(jtag_TCK), .jtag_TRST(jtag_TRST), .core_clk(core_clk),
    .tck_req_valid(tck_req_valid), .tck_req_ready(tck_req_ready), .tck_req_bits(tck_req_bits),
    .tck_resp_valid(tck_resp_valid), .tck_resp_ready(tck_resp_ready), .tck_resp_bits(tck_resp_bits),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_bits(core_req_bits),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready), .core_resp_bits(core_resp_bits)
  );

  real tck_half  = 50.0;
  real core_half = 5.0;
  real core_skew = 2.3;

  always begin #(tck_half) jtag_TCK = ~jtag_TCK; end
  always begin #(core_half + core_skew) core_skew = 0.0; core_clk = ~core_clk; end

  int n_tests = 0;
  int n_fail  = 0;
  logic [RQW-1:0] exp_req_q[$];
  logic [RSW-1:0] exp_resp_q[$];
  int resp_taken = 0;
  int served     = 0;
  int pulses     = 0;
  bit pv         = 1'b0;
  int req_cnt = 0, req_lat = -1, lat_cnt = 0, resp_lat = -1;
  bit req_arm = 1'b0, lat_arm = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge core_clk) begin
    if (core_req_valid && !pv) pulses++;
    pv = core_req_valid;
  end

  // core_clk edges from request acceptance to core_req_valid
  always @(posedge core_clk) begin
    if (req_arm) begin
      req_cnt++;
      #1;
      if (core_req_valid) begin req_arm = 1'b0; req_lat = req_cnt; end
    end
  end

  // TCK edges from the DM response handshake to tck_resp_valid
  always @(posedge jtag_TCK) begin
    if (lat_arm) begin
      lat_cnt++;
      #1;
      if (tck_resp_valid) begin lat_arm = 1'b0; resp_lat = lat_cnt; end
    end
  end

  task automatic tck_send(input logic [RQW-1:0] req, output int stalls, output int taken_at_acc);
    int n;
    n = 0; stalls = 0; taken_at_acc = -1;
    @(negedge jtag_TCK);
    tck_req_valid = 1'b1;
    tck_req_bits  = req;
    while (!tck_req_ready && n < 4000) begin @(negedge jtag_TCK); n++; stalls++; end
    check_eq("tck_req_accept", tck_req_ready, 1);
    if (!tck_req_ready) begin tck_req_valid = 1'b0; return; end
    exp_req_q.push_back(req);
    taken_at_acc = resp_taken;
    @(posedge jtag_TCK);
    req_cnt = 0; req_arm = 1'b1;
    @(negedge jtag_TCK);
    tck_req_valid = 1'b0;
    check_eq("tck_rdy_low", tck_req_ready, 0);
  endtask

  task automatic tck_recv();
    int n, hold;
    logic [RSW-1:0] e;
    n = 0; e = '0;
    @(negedge jtag_TCK);
    while (!tck_resp_valid && n < 4000) begin @(negedge jtag_TCK); n++; end
    check_eq("tck_resp_valid", tck_resp_valid, 1);
    if (!tck_resp_valid) return;
    check_eq("tck_resp_pending", exp_resp_q.size(), 1);
    if (exp_resp_q.size() > 0) e = exp_resp_q.pop_front();
    check_eq("tck_resp_bits", tck_resp_bits, e);
    hold = $urandom_range(0, 2);
    repeat (hold) @(negedge jtag_TCK);
    check_eq("tck_resp_hold", {tck_resp_valid, tck_resp_bits}, {1'b1, e});
    tck_resp_ready = 1'b1;
    resp_taken++;
    @(negedge jtag_TCK);
    tck_resp_ready = 1'b0;
    check_eq("tck_resp_clear", tck_resp_valid, 0);
  endtask

  // DM model: accepts one request after req_dly cycles, answers after resp_dly cycles
  task automatic dm_serve(input int req_dly, input int resp_dly, input bit fix, input logic [RSW-1:0] fix_rsp,
                          input bit simul);
    int n, bad;
    logic [RQW-1:0] e;
    logic [RSW-1:0] rsp;
    n = 0; e = '0;
    @(negedge core_clk);
    while (!core_req_valid && n < 4000) begin @(negedge core_clk); n++; end
    check_eq("dm_req_valid", core_req_valid, 1);
    if (!core_req_valid) return;
    check_eq("dm_req_pending", exp_req_q.size(), 1);
    if (exp_req_q.size() > 0) e = exp_req_q.pop_front();
    check_eq("dm_req_bits", core_req_bits, e);
    bad = 0;
    repeat (req_dly) begin
      @(negedge core_clk);
      if (!core_req_valid || core_req_bits !== e) bad++;
    end
    if (req_dly > 0) check_eq("dm_req_hold", bad, 0);
    rsp = fix ? fix_rsp : RSW'({$urandom, $urandom});
    core_req_ready = 1'b1;
    if (simul) begin core_resp_valid = 1'b1; core_resp_bits = ~rsp; end
    @(negedge core_clk);
    core_req_ready = 1'b0; core_resp_valid = 1'b0;
    check_eq("dm_wait_ready", core_resp_ready, 1);
    bad = 0;
    repeat (resp_dly) begin
      @(negedge core_clk);
      if (!core_resp_ready || core_req_valid) bad++;
    end
    if (resp_dly > 0) check_eq("dm_wait_hold", bad, 0);
    exp_resp_q.push_back(rsp);
    core_resp_valid = 1'b1;
    core_resp_bits  = rsp;
    @(posedge core_clk);
    lat_cnt = 0; lat_arm = 1'b1;
    @(negedge core_clk);
    core_resp_valid = 1'b0;
    check_eq("dm_resp_done", core_resp_ready, 0);
    served++;
  endtask

  task automatic run_txn(input logic [RQW-1:0] req, input int rd, input int sd, input bit fix,
                         input logic [RSW-1:0] fr, input bit simul);
    int st, ta;
    fork
      begin tck_send(req, st, ta); tck_recv(); end
      dm_serve(rd, sd, fix, fr, simul);
    join
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req_ready"},  tck_req_ready, 1);
    check_eq({pfx, "_resp_valid"}, tck_resp_valid, 0);
    check_eq({pfx, "_resp_bits"},  tck_resp_bits, 0);
    check_eq({pfx, "_core_valid"}, core_req_valid, 0);
    check_eq({pfx, "_core_bits"},  core_req_bits, 0);
    check_eq({pfx, "_core_rready"}, core_resp_ready, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int st_a, ta_a, st_b, ta_b, base, sbase, spur, rdy_hi;
    tck_req_valid = 1'b0; tck_req_bits = '0; tck_resp_ready = 1'b0;
    core_req_ready = 1'b0; core_resp_valid = 1'b0; core_resp_bits = '0;
    #1 jtag_TRST = 1'b1;
    repeat (3) @(negedge jtag_TCK);
    check_reset_outputs("rst");
    jtag_TRST = 1'b0;
    repeat (3) @(negedge jtag_TCK);

    // basic write with exact crossing latencies
    req_lat = -1; resp_lat = -1;
    run_txn({5'h10, 34'h0_DEAD_BEEF, 2'b10}, 0, 0, 1'b1, 36'h0, 1'b0);
    check_eq("basic_req_lat", req_lat, SYNC + 1);
    check_eq("basic_resp_lat", resp_lat, SYNC + 1);

    // back-pressure: second request waits for the first response
    pulses = 0; base = resp_taken;
    fork
      begin
        tck_send({5'h03, 34'h2_0000_0001, 2'b01}, st_a, ta_a);
        tck_send({5'h1F, 34'h3_FFFF_FFFE, 2'b10}, st_b, ta_b);
      end
      begin tck_recv(); tck_recv(); end
      begin dm_serve(2, 2, 1'b0, '0, 1'b0); dm_serve(0, 0, 1'b0, '0, 1'b0); end
    join
    check_eq("bp_stalled", st_b > 0, 1);
    check_eq("bp_order", ta_b, base + 1);
    check_eq("bp_pulses", pulses, 2);

    // slow DM, and a response offered together with the request handshake
    run_txn({5'h0A, 34'h1_5555_AAAA, 2'b01}, 20, 50, 1'b1, {34'h1_2345_6789, 2'b11}, 1'b0);
    run_txn({5'h05, 34'h0_1234_5678, 2'b10}, 1, 2, 1'b0, '0, 1'b1);

    // reset while the core side waits for the DM response
    fork
      begin tck_send({5'h11, 34'h0_CAFE_F00D, 2'b10}, st_a, ta_a); end
      begin
        spur = 0;
        while (!core_req_valid && spur < 1000) begin @(negedge core_clk); spur++; end
        check_eq("rstm_req_valid", core_req_valid, 1);
        core_req_ready = 1'b1;
        @(negedge core_clk);
        core_req_ready = 1'b0;
        check_eq("rstm_in_wait", core_resp_ready, 1);
      end
    join
    #3 jtag_TRST = 1'b1;
    #1 check_reset_outputs("rstm");
    exp_req_q.delete(); exp_resp_q.delete();
    repeat (2) @(negedge jtag_TCK);
    jtag_TRST = 1'b0;
    rdy_hi = 0; spur = 0;
    @(negedge core_clk);
    core_resp_valid = 1'b1; core_resp_bits = 36'hA_BCDE_F012;
    repeat (10) begin @(negedge core_clk); if (core_resp_ready) rdy_hi++; end
    core_resp_valid = 1'b0;
    repeat (30) begin @(negedge jtag_TCK); if (tck_resp_valid) spur++; end
    check_eq("rstm_no_rready", rdy_hi, 0);
    check_eq("rstm_no_resp", spur, 0);
    check_eq("rstm_req_ready", tck_req_ready, 1);
    run_txn({5'h12, 34'h3_0F0F_0F0F, 2'b01}, 1, 1, 1'b0, '0, 1'b0);

    // clock ratio sweep: core at 0.3x, 1x and 7x TCK
    for (int r = 0; r < 3; r++) begin
      core_half = (r == 0) ? tck_half / 0.3 : (r == 1) ? tck_half : tck_half / 7.0;
      core_skew = real'($urandom_range(1, 97)) + 0.37;
      repeat (4) @(negedge jtag_TCK);
      base = resp_taken; sbase = served;
      for (int t = 0; t < 200; t++) begin
        run_txn(RQW'({$urandom, $urandom}), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, '0,
                $urandom_range(0, 3) == 0);
      end
      check_eq("sweep_recv", resp_taken - base, 200);
      check_eq("sweep_served", served - sbase, 200);
      check_eq("sweep_q_empty", exp_req_q.size() + exp_resp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
